io_input_debounce: RTL and testbench
====================================

IO_INPUT_DEBOUNCE -- requirements
Module: io_input_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, number of consecutive io_clk cycles a changed input must hold before it is accepted (legal range 1..65535).
REQ-002 The block SHALL have port io_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port raw_port0, input, 4, asynchronous switch/key inputs, group 0.
REQ-005 The block SHALL have port raw_port1, input, 4, asynchronous switch/key inputs, group 1.
REQ-006 The block SHALL have port in_port0, output, 4, debounced group 0, driving the in_port0 input of the input register stage.
REQ-007 The block SHALL have port in_port1, output, 4, debounced group 1, driving the in_port1 input of the input register stage.
REQ-008 The block SHALL have port change_pulse, output, 1, a one-cycle pulse on any debounced bit change.

Function
REQ-009 Each of the 8 raw bits SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each bit SHALL own a 16-bit counter and a stable register; the stable register drives the corresponding output bit directly.
REQ-011 When synced bit equals stable bit, the counter SHALL be cleared to 0 on that edge.
REQ-012 When synced bit differs from stable and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 When synced bit differs and counter == DEBOUNCE_CYCLES-1, stable SHALL take the synced value and the counter SHALL clear on the same edge.
REQ-014 Latency: a raw change held steady SHALL appear on the output exactly DEBOUNCE_CYCLES+2 rising edges after it is first sampled by synchronizer stage 1.
REQ-015 A glitch (synced mismatch lasting fewer than DEBOUNCE_CYCLES cycles) SHALL leave the output unchanged and restart counting from 0 on the next mismatch.
REQ-016 DEBOUNCE_CYCLES == 1 SHALL accept a change on its first mismatched cycle (latency 3 edges); the counter never leaves 0.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-018 Bits SHALL be fully independent; simultaneous changes on several bits each obey REQ-011..REQ-013 separately.
REQ-019 change_pulse SHALL be 1 for exactly the cycle after any stable bit updates, 0 otherwise; multiple simultaneous updates yield one single-cycle pulse.

Reset
REQ-020 While reset is 1 at a rising edge, synchronizer flops, stable registers, counters, in_port0, in_port1 and change_pulse SHALL all become 0.
REQ-021 Reset asserted mid-count SHALL discard the count; after release, a held raw 1 SHALL need the full DEBOUNCE_CYCLES+2 edges again.
REQ-022 No change_pulse SHALL be generated by reset itself or by its release.

Configuration
REQ-023 With macro IO_DEBOUNCE_EDGE_EN defined, the block SHALL add outputs rise_port0 and rise_port1 (4 bits each), each bit a one-cycle pulse in the cycle after its stable bit goes 0->1, reset to 0.
REQ-024 Without IO_DEBOUNCE_EDGE_EN, those ports and their registers SHALL not exist; all other behaviour is identical.

Structure
REQ-025 A shared package SHALL hold the default DEBOUNCE_CYCLES, the counter width (16), and the port group width (4).
REQ-026 One sub-module debounce_bit (synchronizer, counter, stable register, optional edge flop) SHALL be instantiated 8 times; the top only wires groups and ORs change indications.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-027 Reset, then raw_port0=4'b0101 held -> in_port0 stays 0 for 5 edges, becomes 4'b0101 on edge 6; change_pulse high one cycle after.
REQ-028 raw_port1[2] pulsed high for 3 cycles -> in_port1 stays 4'b0000, change_pulse never asserts.
REQ-029 Bit bounces 1,0,1 then held 1 -> output rises only 6 edges after the final stable 1 reaches stage 1.
REQ-030 Reset asserted after 2 mismatch cycles with raw held 1 -> output 0; after release rises 6 edges later.
REQ-031 raw_port0=4'b1111 and raw_port1=4'b1000 changed together -> both groups update on the same edge; change_pulse exactly one cycle wide.
REQ-032 With IO_DEBOUNCE_EDGE_EN, raw_port0[0] 0->1->0 each held 10 cycles -> rise_port0[0] pulses once, on the cycle after in_port0[0] rises, none on the fall.

Source files
------------

// File: rtl/io_input_debounce_pkg.sv
// Shared sizing and defaults for the io_input_debounce slice.
// Optional rise-edge outputs are enabled by IO_DEBOUNCE_EDGE_EN.
package io_input_debounce_pkg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned GRP_W   = 4;
  localparam int unsigned NUM_GRP = 2;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [GRP_W-1:0] grp_t;

  localparam cnt_t DEBOUNCE_DEFAULT = 16'd50000;

endpackage

// File: rtl/io_input_debounce_if.sv
// Raw switch inputs and debounced outputs of io_input_debounce.
// rise_port0/rise_port1 exist only with IO_DEBOUNCE_EDGE_EN.
interface io_input_debounce_if;
  import io_input_debounce_pkg::*;

  grp_t raw_port0;
  grp_t raw_port1;
  grp_t in_port0;
  grp_t in_port1;
  logic change_pulse;
`ifdef IO_DEBOUNCE_EDGE_EN
  grp_t rise_port0;
  grp_t rise_port1;
`endif

  modport master (
    output raw_port0,
    output raw_port1,
    input  in_port0,
    input  in_port1,
`ifdef IO_DEBOUNCE_EDGE_EN
    input  rise_port0,
    input  rise_port1,
`endif
    input  change_pulse
  );

  modport slave (
    input  raw_port0,
    input  raw_port1,
    output in_port0,
    output in_port1,
`ifdef IO_DEBOUNCE_EDGE_EN
    output rise_port0,
    output rise_port1,
`endif
    output change_pulse
  );

endinterface

// File: rtl/io_input_debounce_bit.sv
// One debounced bit: 2-flop synchronizer, hold counter, stable register.
// The rise-edge flop is present only with IO_DEBOUNCE_EDGE_EN.
module debounce_bit
  import io_input_debounce_pkg::*;
#(
  parameter cnt_t DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
`ifdef IO_DEBOUNCE_EDGE_EN
  output logic rise_o,
`endif
  output logic change_o
);

  localparam cnt_t LAST = DEBOUNCE_CYCLES - cnt_t'(1);

  logic sync1_q, sync2_q;
  logic stable_q, stable_d;
  cnt_t cnt_q, cnt_d;
  logic upd_q, upd_d;
  logic chg_q;

  // Counter runs only while the synced value disagrees; it never passes LAST.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    upd_d    = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
        upd_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  // upd_q marks the acceptance edge; chg_q delays it so the pulse follows the update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      chg_q    <= upd_q;
    end
  end

`ifdef IO_DEBOUNCE_EDGE_EN
  logic rise_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= upd_q & stable_q;
    end
  end

  assign rise_o = rise_q;
`endif

  assign stable_o = stable_q;
  assign change_o = chg_q;

endmodule

// File: rtl/io_input_debounce.sv
// Debounces two 4-bit switch groups; one debounce_bit per raw input.
// Define IO_DEBOUNCE_EDGE_EN to add rise_port0/rise_port1 pulse outputs.
module io_input_debounce
  import io_input_debounce_pkg::*;
#(
  parameter cnt_t DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input logic          io_clk,
  input logic          reset,
  io_input_debounce_if.slave io
);

  localparam int unsigned NBITS = NUM_GRP * GRP_W;

  logic [NBITS-1:0] raw_w;
  logic [NBITS-1:0] stable_w;
  logic [NBITS-1:0] change_w;
`ifdef IO_DEBOUNCE_EDGE_EN
  logic [NBITS-1:0] rise_w;
`endif

  assign raw_w = {io.raw_port1, io.raw_port0};

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i   (io_clk),
      .rst_i   (reset),
      .raw_i   (raw_w[i]),
      .stable_o(stable_w[i]),
`ifdef IO_DEBOUNCE_EDGE_EN
      .rise_o  (rise_w[i]),
`endif
      .change_o(change_w[i])
    );
  end

  assign io.in_port0     = stable_w[GRP_W-1:0];
  assign io.in_port1     = stable_w[NBITS-1:GRP_W];
  assign io.change_pulse = |change_w;
`ifdef IO_DEBOUNCE_EDGE_EN
  assign io.rise_port0   = rise_w[GRP_W-1:0];
  assign io.rise_port1   = rise_w[NBITS-1:GRP_W];
`endif

endmodule

// File: tb/tb_io_input_debounce.sv
// Bench for io_input_debounce with DEBOUNCE_CYCLES=4; checks against a
// window-based reference model plus explicit tables and corner sequences.
module tb_io_input_debounce;

  localparam int D    = 4;
  localparam int MAXC = 2048;

  logic io_clk = 1'b0;
  logic reset;

  io_input_debounce_if bus_if();

  io_input_debounce #(
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .io_clk(io_clk),
    .reset (reset),
    .io    (bus_if)
  );

  always #5 io_clk = ~io_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference history: raw value seen at each edge (0 on reset edges).
  logic [7:0] rs [MAXC];
  bit         rh [MAXC];
  int         n = -1;
  logic [7:0] m_stable, m_upd, e_rise;
  logic       e_pulse;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // Value the debouncer compares at edge m: raw from two edges earlier,
  // or 0 if a reset has cleared the synchronizer in between.
  function automatic logic cmpv(input int b, input int m);
    if (m >= 1 && rh[m-1]) return 1'b0;
    if (m < 2) return 1'b0;
    return rs[m-2][b];
  endfunction

  // A bit flips when its last D compared values all disagree with it.
  function automatic bit window_mismatch(input int b, input int m, input logic s);
    for (int k = 0; k < D; k++) begin
      if (m - k < 0) return 1'b0;
      if (rh[m-k]) return 1'b0;
      if (cmpv(b, m - k) == s) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input logic [3:0] r0, input logic [3:0] r1, input logic rst);
    logic [7:0] nu;
    bus_if.raw_port0 = r0;
    bus_if.raw_port1 = r1;
    reset = rst;
    @(posedge io_clk);
    #1;
    n++;
    if (n >= MAXC) begin
      $display("FAIL history_overflow at edge %0d: got %0d expected <%0d", n, n, MAXC);
      $fatal(1);
    end
    rh[n] = rst;
    rs[n] = rst ? 8'h00 : {r1, r0};
    if (rst) begin
      m_stable = '0;
      m_upd    = '0;
      e_pulse  = 1'b0;
      e_rise   = '0;
    end else begin
      e_pulse = |m_upd;
      e_rise  = m_upd & m_stable;
      nu = '0;
      for (int b = 0; b < 8; b++) nu[b] = window_mismatch(b, n, m_stable[b]);
      m_stable = m_stable ^ nu;
      m_upd    = nu;
    end
    check("model_in_port0", bus_if.in_port0, m_stable[3:0]);
    check("model_in_port1", bus_if.in_port1, m_stable[7:4]);
    check("model_change_pulse", bus_if.change_pulse, e_pulse);
`ifdef IO_DEBOUNCE_EDGE_EN
    check("model_rise_port0", bus_if.rise_port0, e_rise[3:0]);
    check("model_rise_port1", bus_if.rise_port1, e_rise[7:4]);
`endif
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] r0, r1, e0, e1;
    logic       ep;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL timeout at edge %0d: got running expected finished", n);
    $fatal(1);
  end

  initial begin
    logic [7:0] cur;
    logic       rr;
    int         cnt, inrise, riseedge;
    logic       prev;

    // Basic acceptance: held 0101 appears on edge 6, pulse on edge 7.
    tbl[0] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    for (int i = 1; i <= 5; i++) tbl[i] = '{1'b0, 4'b0101, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[6] = '{1'b0, 4'b0101, 4'h0, 4'b0101, 4'h0, 1'b0};
    tbl[7] = '{1'b0, 4'b0101, 4'h0, 4'b0101, 4'h0, 1'b1};
    tbl[8] = '{1'b0, 4'b0101, 4'h0, 4'b0101, 4'h0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r0, tbl[i].r1, tbl[i].rst);
      check("tbl_in_port0", bus_if.in_port0, tbl[i].e0);
      check("tbl_in_port1", bus_if.in_port1, tbl[i].e1);
      check("tbl_change_pulse", bus_if.change_pulse, tbl[i].ep);
    end

    // Short glitch on raw_port1[2] is rejected.
    step(4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step(4'h0, (i < 3) ? 4'b0100 : 4'b0000, 1'b0);
      check("glitch_in_port1", bus_if.in_port1, 4'h0);
      check("glitch_pulse", bus_if.change_pulse, 1'b0);
    end

    // Bounce 1,0,1 then hold: output rises 6 edges after the final 1 is sampled.
    step(4'h0, 4'h0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step((i == 2) ? 4'b0000 : 4'b1000, 4'h0, 1'b0);
      check("bounce_in_port0", bus_if.in_port0, (i >= 8) ? 4'b1000 : 4'b0000);
    end

    // Reset mid-count discards progress; full latency needed after release.
    step(4'h0, 4'h0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(4'b0010, 4'h0, 1'b0);
      check("pre_reset_in_port0", bus_if.in_port0, 4'h0);
    end
    step(4'b0010, 4'h0, 1'b1);
    check("reset_in_port0", bus_if.in_port0, 4'h0);
    check("reset_pulse", bus_if.change_pulse, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(4'b0010, 4'h0, 1'b0);
      check("release_in_port0", bus_if.in_port0, (i >= 6) ? 4'b0010 : 4'b0000);
      check("release_pulse", bus_if.change_pulse, (i == 7) ? 1'b1 : 1'b0);
    end

    // Both groups change together: same update edge, single one-cycle pulse.
    step(4'h0, 4'h0, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      step(4'b1111, 4'b1000, 1'b0);
      check("both_in_port0", bus_if.in_port0, (i >= 6) ? 4'b1111 : 4'b0000);
      check("both_in_port1", bus_if.in_port1, (i >= 6) ? 4'b1000 : 4'b0000);
      check("both_pulse", bus_if.change_pulse, (i == 7) ? 1'b1 : 1'b0);
    end

`ifdef IO_DEBOUNCE_EDGE_EN
    // Rise pulse once, on the edge after in_port0[0] rises, none on the fall.
    step(4'h0, 4'h0, 1'b1);
    cnt = 0;
    inrise = -1;
    riseedge = -1;
    prev = 1'b0;
    for (int i = 1; i <= 28; i++) begin
      step((i <= 10) ? 4'b0001 : 4'b0000, 4'h0, 1'b0);
      if (bus_if.in_port0[0] && !prev) inrise = i;
      prev = bus_if.in_port0[0];
      if (bus_if.rise_port0[0]) begin
        cnt++;
        riseedge = i;
      end
    end
    check("rise_count", 8'(cnt), 8'd1);
    check("rise_edge", 8'(riseedge), 8'(inrise + 1));
`endif

    // Random bouncing inputs with occasional resets against the model.
    step(4'h0, 4'h0, 1'b1);
    cur = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      end
      rr = ($urandom_range(0, 199) == 0);
      step(cur[3:0], cur[7:4], rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
